fir_outstage: RTL and testbench

Output stage for the FIR tap chain. It takes the full-width accumulator from the last tap, decimates it by a fixed ratio, applies convergent rounding and a right shift, and saturates to the output width. Results are buffered in a small first-word-fall-through FIFO and handed to the consumer over a valid/ready handshake. Sticky status flags report saturation and FIFO overflow.

---
 rtl/fir_outstage.sv | 163 ++++++++++++++++
 tb/tb_fir_outstage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_outstage.sv
// ----------------------------------------------------------------------------
// fir_outstage : decimate, round-half-even, scale/saturate, FWFT output FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fir_outstage #(
   parameter int IW      = 40,
   parameter int OW      = 16,
   parameter int SHIFT   = 15,
   parameter int DECIM   = 2,
   parameter int LGDEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_ce,
   input  logic signed [IW-1:0] i_acc,
   input  logic                 i_clr_flags,
   output logic [OW-1:0]        o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [LGDEPTH:0]     o_level,
   output logic                 o_sat,
   output logic                 o_overflow
);

   localparam int c_depth = 1 << LGDEPTH;
   localparam int c_qw    = IW - SHIFT + 1;
   localparam int c_dcw   = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [c_dcw-1:0]   c_dlast = c_dcw'(DECIM - 1);
   localparam logic [SHIFT-1:0]   c_half  = SHIFT'(1) << (SHIFT - 1);
   localparam logic [LGDEPTH:0]   c_msb   = (LGDEPTH+1)'(1) << LGDEPTH;

   logic [c_dcw-1:0]   r_dcnt;
   logic               w_keep;
   logic               w_carry;
   logic [c_qw-1:0]    w_q_nxt;
   logic               r_v1;
   logic [c_qw-1:0]    r_q;

   logic [c_qw-OW:0]   w_hi;
   logic               w_inrange;
   logic [OW-1:0]      w_res;
   logic               w_sat_evt;

   logic [OW-1:0]      r_mem [c_depth];
   logic [LGDEPTH:0]   r_wptr;
   logic [LGDEPTH:0]   r_rptr;
   logic [LGDEPTH:0]   r_level;
   logic [LGDEPTH:0]   w_level_nxt;
   logic               r_valid;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_ovf_evt;
   logic               r_sat;
   logic               r_ovf;

   assign w_keep = i_ce && (r_dcnt == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dcnt <= '0;
      end else if (i_ce) begin
         r_dcnt <= (r_dcnt == c_dlast) ? '0 : r_dcnt + c_dcw'(1);
      end
   end

   // Only the quotient of the rounded value is kept: the rounding constant
   // plus the half-even bit carries into bit SHIFT exactly when this holds.
   always_comb begin
      w_carry = i_acc[SHIFT] ? (i_acc[SHIFT-1:0] >= c_half)
                             : (i_acc[SHIFT-1:0] >  c_half);
      w_q_nxt = {i_acc[IW-1], i_acc[IW-1:SHIFT]} + c_qw'(w_carry);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1 <= 1'b0;
         r_q  <= '0;
      end else begin
         r_v1 <= w_keep;
         if (w_keep) begin
            r_q <= w_q_nxt;
         end
      end
   end

   always_comb begin
      w_hi      = r_q[c_qw-1:OW-1];
      w_inrange = (&w_hi) | ~(|w_hi);
      if (w_inrange) begin
         w_res = r_q[OW-1:0];
      end else if (r_q[c_qw-1]) begin
         w_res = {1'b1, {(OW-1){1'b0}}};
      end else begin
         w_res = {1'b0, {(OW-1){1'b1}}};
      end
      w_sat_evt = r_v1 && !w_inrange;
   end

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = ((r_wptr ^ r_rptr) == c_msb);
   assign w_pop     = !w_empty && i_ready;
   assign w_push    = r_v1 && (!w_full || w_pop);
   assign w_ovf_evt = r_v1 && w_full && !w_pop;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + (LGDEPTH+1)'(1);
         2'b01:   w_level_nxt = r_level - (LGDEPTH+1)'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < c_depth; k++) begin
            r_mem[k] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr[LGDEPTH-1:0]] <= w_res;
            r_wptr <= r_wptr + (LGDEPTH+1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (LGDEPTH+1)'(1);
         end
         r_level <= w_level_nxt;
         r_valid <= (w_level_nxt != '0);
      end
   end

   // A set event on the same edge as a clear takes priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sat <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_sat_evt)        r_sat <= 1'b1;
         else if (i_clr_flags) r_sat <= 1'b0;
         if (w_ovf_evt)        r_ovf <= 1'b1;
         else if (i_clr_flags) r_ovf <= 1'b0;
      end
   end

   assign o_data     = r_mem[r_rptr[LGDEPTH-1:0]];
   assign o_valid    = r_valid;
   assign o_level    = r_level;
   assign o_sat      = r_sat;
   assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fir_outstage.sv
// ----------------------------------------------------------------------------
// tb_fir_outstage : directed vectors, queue scoreboard with decoupled monitor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fir_outstage;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_ce;
   logic [39:0]   i_acc;
   logic          i_clr_flags;
   logic [15:0]   o_data;
   logic          o_valid;
   logic          i_ready;
   logic [2:0]    o_level;
   logic          o_sat;
   logic          o_overflow;

   int            n_vec = 0;
   int            n_err = 0;
   logic [15:0]   sb_q[$];
   logic [15:0]   m_exp;
   logic [31:0]   pat = 32'hB2D63ACD;

   always #5 clk = ~clk;

   fir_outstage #(
      .IW(40), .OW(16), .SHIFT(15), .DECIM(2), .LGDEPTH(2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ce        (i_ce),
      .i_acc       (i_acc),
      .i_clr_flags (i_clr_flags),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_level     (o_level),
      .o_sat       (o_sat),
      .o_overflow  (o_overflow)
   );

   // Pop happens at the next rising edge when o_valid && i_ready here.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got %h, expected no output", o_data);
         end else begin
            m_exp = sb_q.pop_front();
            if (o_data !== m_exp) begin
               n_err++;
               $display("FAIL out_data: got %h, expected %h", o_data, m_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [39:0] acc, input logic [15:0] ev, input bit keep);
      i_ce  = 1'b1;
      i_acc = acc;
      if (keep) sb_q.push_back(ev);
      tick();
      i_ce  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      i_ready = 1'b1;
      while ((sb_q.size() != 0 || o_valid) && t < 60) begin
         tick();
         t++;
      end
      chk("drain_queue", sb_q.size(), 0);
      chk("drain_valid", o_valid, 0);
   endtask

   task automatic clr_pulse();
      i_clr_flags = 1'b1;
      tick();
      i_clr_flags = 1'b0;
   endtask

   logic [39:0] rv[5] = '{40'sd16384, 40'sd49152, 40'sd81920, -40'sd49152, 40'sd32767};
   logic [15:0] re[5] = '{16'd0, 16'd2, 16'd2, 16'hFFFE, 16'd1};

   initial begin
      rst_n = 1'b0; i_ce = 1'b0; i_acc = '0; i_clr_flags = 1'b0; i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_level", o_level, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_data", o_data, 0);
      rst_n = 1'b1;
      tick();

      // Rounding: every other strobe is decimated away
      i_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(rv[i], re[i], 1'b1);
         send(40'd0, 16'd0, 1'b0);
      end
      drain();
      chk("round_sat", o_sat, 0);

      // Saturation, clear, and set-beats-clear
      send(40'h0040000000, 16'h7FFF, 1'b1);
      send(40'd0, 16'd0, 1'b0);
      tick();
      chk("sat_pos", o_sat, 1);
      clr_pulse();
      chk("sat_clr", o_sat, 0);
      send(40'hF800000000, 16'h8000, 1'b1);
      i_clr_flags = 1'b1;
      send(40'd0, 16'd0, 1'b0);
      i_clr_flags = 1'b0;
      chk("sat_set_wins", o_sat, 1);
      clr_pulse();
      chk("sat_clr2", o_sat, 0);
      drain();

      // Decimation, back to back then with idle gaps
      for (int k = 1; k <= 6; k++) send(40'(k) << 15, 16'(k), (k % 2) == 1);
      drain();
      for (int k = 1; k <= 6; k++) begin
         send(40'(k) << 15, 16'(k), (k % 2) == 1);
         tick();
         tick();
      end
      drain();

      // Overflow: fifth kept sample is dropped
      chk("ovf_idle", o_overflow, 0);
      i_ready = 1'b0;
      for (int v = 10; v <= 14; v++) begin
         send(40'(v) << 15, 16'(v), v != 14);
         send(40'd0, 16'd0, 1'b0);
      end
      tick();
      chk("ovf_level", o_level, 4);
      chk("ovf_flag", o_overflow, 1);
      chk("ovf_valid", o_valid, 1);
      drain();
      chk("ovf_level_empty", o_level, 0);
      clr_pulse();
      chk("ovf_clr", o_overflow, 0);

      // Full FIFO with write and pop on the same edge
      i_ready = 1'b0;
      for (int v = 20; v <= 23; v++) begin
         send(40'(v) << 15, 16'(v), 1'b1);
         send(40'd0, 16'd0, 1'b0);
      end
      tick();
      chk("full_level", o_level, 4);
      send(40'd24 << 15, 16'd24, 1'b1);
      i_ready = 1'b1;
      send(40'd0, 16'd0, 1'b0);
      i_ready = 1'b0;
      chk("full_wp_level", o_level, 4);
      chk("full_wp_ovf", o_overflow, 0);
      drain();

      // Backpressure with a fixed ready pattern and a continuous ramp
      for (int k = 0; k < 64; k++) begin
         i_ready = pat[k % 32];
         send(40'(100 + k / 2) << 15, 16'(100 + k / 2), (k % 2) == 0);
         chk("bp_level_max", o_level <= 3'd4, 1);
      end
      drain();
      chk("bp_ovf", o_overflow, 0);

      // Asynchronous reset with level 3 and stage 1 occupied
      i_ready = 1'b0;
      send(40'h0040000000, 16'd0, 1'b0);
      send(40'd0, 16'd0, 1'b0);
      send(40'd31 << 15, 16'd0, 1'b0);
      send(40'd0, 16'd0, 1'b0);
      send(40'd32 << 15, 16'd0, 1'b0);
      send(40'd0, 16'd0, 1'b0);
      tick();
      chk("pre_rst_level", o_level, 3);
      chk("pre_rst_sat", o_sat, 1);
      send(40'd33 << 15, 16'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_level", o_level, 0);
      chk("arst_sat", o_sat, 0);
      chk("arst_ovf", o_overflow, 0);
      chk("arst_data", o_data, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      i_ready = 1'b1;
      send(40'd7 << 15, 16'd7, 1'b1);
      chk("lat_edge1_valid", o_valid, 0);
      tick();
      chk("lat_edge2_valid", o_valid, 1);
      chk("lat_edge2_data", o_data, 7);
      drain();

      chk("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
